pong_ball: RTL and testbench
============================

# pong_ball

Ball motion engine for the pong game. It steps the ball across the 800 x 480 playfield, reflects it off the top and bottom walls and off both paddles, detects misses, and keeps both scores. It sits directly upstream of the computer-player block, which consumes `BALL_H`/`BALL_V`, and of the renderer. It consumes the human paddle position and the computer paddle `POSITION`.

## Interface
- `STEP_TICKS`, default 12421771: clock cycles per ball step.
- `PAUSE_TICKS`, default 50000000: cycles the ball is frozen after a point.
- `WIN_SCORE`, default 9: score that ends the game.
- `CLOCK` input, 1 bit: the single system clock.
- `RESET_N` input, 1 bit: asynchronous, active-low reset.
- `SERVE` input, 1 bit: level, sampled each cycle; launches the ball or restarts the game.
- `PADDLE_L` input, 8 bits: human paddle position in units 0..25.
- `PADDLE_R` input, 8 bits: computer paddle position in units 0..25.
- `BALL_H` output, 11 bits: ball column, 0..799.
- `BALL_V` output, 11 bits: ball row, 0..474.
- `SCORE_L` output, 4 bits: human score.
- `SCORE_R` output, 4 bits: computer score.
- `IN_PLAY` output, 1 bit: high while the ball is moving.
- `HIT` output, 1 bit: one-cycle pulse on a paddle reflection.

## Operation
- States:
  - IDLE: ball at centre, waits for `SERVE`.
  - MOVE: ball steps.
  - SCORED: frozen for `PAUSE_TICKS`.
  - OVER: a score has reached `WIN_SCORE`.
- Transitions:
  - IDLE to MOVE on `SERVE`=1.
  - MOVE to SCORED on a miss.
  - SCORED to IDLE after the pause, or to OVER if a score equals `WIN_SCORE`.
  - OVER to IDLE on `SERVE`=1. This transition clears both scores.
  - `SERVE` is ignored in MOVE and SCORED.
- Direction registers:
  - `dx`: 1 means H increasing.
  - `dy`: 1 means V increasing.
- Each step in MOVE:
  - Vertical: V moves ±1. At V=0 moving up, `dy` becomes 1 and V becomes 1. At V=474 moving down, `dy` becomes 0 and V becomes 473.
  - Right paddle: at H=770 moving right, check for a hit. A hit is `PADDLE_R`*16 ≤ V ≤ `PADDLE_R`*16+79, using the pre-step V. On a hit, `dx` becomes 0, H becomes 769 and `HIT` pulses. On a miss, H continues.
  - Left paddle: mirrored at H=10 using `PADDLE_L`. On a hit, H becomes 11.
  - Miss: H reaching 799 gives `SCORE_L`+1. H reaching 0 gives `SCORE_R`+1. Either enters SCORED.
  - Corner case: the wall and paddle reflections apply in the same step.
- Paddle arithmetic is 11 bits wide: position×16 by left shift, +79. No overflow occurs for positions 0..25. Positions above 25 are treated as 25.
- Entering IDLE:
  - H=390, V=237.
  - `dx` points toward the side that conceded the last point, or right after a reset or restart.
  - `dy` toggles on every serve. The first serve after reset uses `dy`=1.
- Scores saturate at `WIN_SCORE`.

## Timing
- Reset values:
  - `BALL_H`=390, `BALL_V`=237.
  - `SCORE_L`=`SCORE_R`=0.
  - `IN_PLAY`=0, `HIT`=0.
  - State IDLE, `dx`=1, `dy`=1.
  - Step counter 0.
- Step counter:
  - Counts 0..`STEP_TICKS`-1 in MOVE. A step is applied on the cycle the counter equals `STEP_TICKS`-1, and the counter wraps to 0 on that cycle.
  - Cleared to 0 in every other state. It is reused as the pause counter in SCORED.
- `SERVE` sampled high in IDLE: `IN_PLAY`=1 on the next cycle. The first position change follows `STEP_TICKS` cycles later.
- Miss step: the score updates and `IN_PLAY` falls on that same clock edge.
- `HIT` is high for exactly one cycle, registered with the reflecting step.
- Outputs are all registered. `BALL_H`/`BALL_V` change at most once per step, so the downstream direction logic sees consecutive single-unit moves.
- `RESET_N` low mid-play forces all reset values immediately, asynchronously. Release is synchronised by the clock edge.

## Structure
- Shared package `pong_pkg`:
  - Screen constants: H_MAX=799, V_MAX=474, NET_H=390, CENTRE_V=237, PAD_L_H=10, PAD_R_H=770, PAD_UNIT=16, PAD_LEN=80, POS_MAX=25.
  - State enum.
  - Constants shared with the computer-player and renderer blocks.
- One sub-module, `pong_step_timer`: a parameterised tick counter with enable and clear, producing a one-cycle `tick`. It is used for both the step period and the pause period.
- Paddle hit compare is combinational inside `pong_ball`.

## Test plan
All scenarios use `STEP_TICKS`=2 and `PAUSE_TICKS`=4.
- Reset, then `SERVE` pulse: `IN_PLAY`=1 next cycle. After 2 cycles, H=391 and V=238. After 4 cycles, H=392 and V=239.
- Ball forced to V=1, `dy`=0: next step V=0, following step V=1 with `dy`=1. H keeps advancing with no `HIT`.
- `PADDLE_R`=14 (rows 224..303), ball reaching H=770 at V=237 moving right: next step H=769, `dx`=0, `HIT` high for one cycle.
- `PADDLE_R`=0, ball at V=237 moving right: ball passes 770 and reaches 799. Then `SCORE_L`=1, `IN_PLAY`=0. After 4 cycles the state is IDLE with H=390, V=237, `dx`=1.
- `SCORE_R`=8, left miss: `SCORE_R`=9, then OVER after the pause. `SERVE` in OVER gives both scores 0 and IDLE.
- `RESET_N` asserted mid-flight at H=500 with `SCORE_L`=3: all outputs return to reset values on the same cycle without a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared playfield geometry, FSM encodings and paddle helpers for the pong blocks.
// Pure declarations: no latency, no flow control.
package pong_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [1:0]  state_t;

    localparam coord_t H_MAX    = 11'd799;
    localparam coord_t V_MAX    = 11'd474;
    localparam coord_t NET_H    = 11'd390;
    localparam coord_t CENTRE_V = 11'd237;
    localparam coord_t PAD_L_H  = 11'd10;
    localparam coord_t PAD_R_H  = 11'd770;
    localparam coord_t PAD_UNIT = 11'd16;
    localparam coord_t PAD_LEN  = 11'd80;
    localparam logic [7:0] POS_MAX = 8'd25;
    localparam int     PAD_SHIFT = 4;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MOVE   = 2'd1;
    localparam state_t ST_SCORED = 2'd2;
    localparam state_t ST_OVER   = 2'd3;

    // Top row of a paddle; out-of-range positions pin to the lowest legal slot.
    function automatic coord_t pad_top(input logic [7:0] pos);
        logic [7:0] p;
        p = (pos > POS_MAX) ? POS_MAX : pos;
        return {3'b000, p} << PAD_SHIFT;
    endfunction

endpackage

// File: rtl/pong_step_timer.sv
// Free-running tick counter: 'tick' is high on the cycle the count equals 'limit'.
// Latency: tick every limit+1 enabled cycles; no backpressure, 'en' holds, 'clr' zeroes.
module pong_step_timer #(
    parameter int W = 27
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == limit);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pong_ball.sv
// Ball motion engine: steps the ball, reflects off walls and paddles, keeps scores.
// Latency: one position update per STEP_TICKS cycles; no backpressure, outputs registered.
module pong_ball
    import pong_pkg::*;
#(
    parameter int STEP_TICKS  = 12421771,
    parameter int PAUSE_TICKS = 50000000,
    parameter int WIN_SCORE   = 9
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        SERVE,
    input  logic [7:0]  PADDLE_L,
    input  logic [7:0]  PADDLE_R,
    output logic [10:0] BALL_H,
    output logic [10:0] BALL_V,
    output logic [3:0]  SCORE_L,
    output logic [3:0]  SCORE_R,
    output logic        IN_PLAY,
    output logic        HIT
);

    localparam int CNT_MAX = (STEP_TICKS > PAUSE_TICKS) ? STEP_TICKS : PAUSE_TICKS;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_TICKS - 1);
    localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_TICKS - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    state_t     state;
    coord_t     ball_h, ball_v;
    logic       dx, dy, serve_dy;
    logic [3:0] score_l, score_r;
    logic       in_play, hit;

    logic   counting, tick;
    coord_t pad_l_top, pad_r_top;
    logic   hit_l, hit_r;
    coord_t nh, nv;
    logic   ndx, ndy, step_hit, miss_l, miss_r;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    // One counter serves as the step period in MOVE and the freeze period in SCORED.
    assign counting = (state == ST_MOVE) || (state == ST_SCORED);

    pong_step_timer #(.W(CW)) u_timer (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .en      (counting),
        .clr     (!counting),
        .limit   ((state == ST_SCORED) ? PAUSE_LAST : STEP_LAST),
        .tick    (tick)
    );

    assign pad_l_top = pad_top(PADDLE_L);
    assign pad_r_top = pad_top(PADDLE_R);
    assign hit_l = (ball_v >= pad_l_top) && (ball_v <= pad_l_top + PAD_LEN - 11'd1);
    assign hit_r = (ball_v >= pad_r_top) && (ball_v <= pad_r_top + PAD_LEN - 11'd1);

    always_comb begin
        nv       = ball_v;
        ndy      = dy;
        nh       = ball_h;
        ndx      = dx;
        step_hit = 1'b0;
        miss_l   = 1'b0;
        miss_r   = 1'b0;

        if (dy) begin
            if (ball_v == V_MAX) begin
                ndy = 1'b0;
                nv  = V_MAX - 11'd1;
            end else begin
                nv  = ball_v + 11'd1;
            end
        end else begin
            if (ball_v == '0) begin
                ndy = 1'b1;
                nv  = 11'd1;
            end else begin
                nv  = ball_v - 11'd1;
            end
        end

        // Paddle test uses the pre-step row, so a wall bounce in the same step does not affect it.
        if (dx) begin
            if ((ball_h == PAD_R_H) && hit_r) begin
                ndx      = 1'b0;
                nh       = PAD_R_H - 11'd1;
                step_hit = 1'b1;
            end else begin
                nh     = ball_h + 11'd1;
                miss_r = (ball_h == H_MAX - 11'd1);
            end
        end else begin
            if ((ball_h == PAD_L_H) && hit_l) begin
                ndx      = 1'b1;
                nh       = PAD_L_H + 11'd1;
                step_hit = 1'b1;
            end else begin
                nh     = ball_h - 11'd1;
                miss_l = (ball_h == 11'd1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            ball_h   <= NET_H;
            ball_v   <= CENTRE_V;
            dx       <= 1'b1;
            dy       <= 1'b1;
            serve_dy <= 1'b1;
            score_l  <= '0;
            score_r  <= '0;
            in_play  <= 1'b0;
            hit      <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (SERVE) begin
                        state    <= ST_MOVE;
                        in_play  <= 1'b1;
                        dy       <= serve_dy;
                        serve_dy <= ~serve_dy;
                    end
                end
                ST_MOVE: begin
                    if (tick) begin
                        ball_h <= nh;
                        ball_v <= nv;
                        dx     <= ndx;
                        dy     <= ndy;
                        hit    <= step_hit;
                        // The next serve heads toward whoever just conceded.
                        if (miss_r) begin
                            score_l <= sat_inc(score_l);
                            dx      <= 1'b1;
                            state   <= ST_SCORED;
                            in_play <= 1'b0;
                        end else if (miss_l) begin
                            score_r <= sat_inc(score_r);
                            dx      <= 1'b0;
                            state   <= ST_SCORED;
                            in_play <= 1'b0;
                        end
                    end
                end
                ST_SCORED: begin
                    if (tick) begin
                        if ((score_l == WIN) || (score_r == WIN)) begin
                            state <= ST_OVER;
                        end else begin
                            state  <= ST_IDLE;
                            ball_h <= NET_H;
                            ball_v <= CENTRE_V;
                        end
                    end
                end
                default: begin
                    if (SERVE) begin
                        state   <= ST_IDLE;
                        score_l <= '0;
                        score_r <= '0;
                        dx      <= 1'b1;
                        ball_h  <= NET_H;
                        ball_v  <= CENTRE_V;
                    end
                end
            endcase
        end
    end

    assign BALL_H  = ball_h;
    assign BALL_V  = ball_v;
    assign SCORE_L = score_l;
    assign SCORE_R = score_r;
    assign IN_PLAY = in_play;
    assign HIT     = hit;

endmodule

// File: tb/tb_pong_ball.sv
// Scoreboard bench for pong_ball: expected output changes are queued with the cycle gap
// since the previous change; a monitor pops one entry per observed output change.
module tb_pong_ball;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        SERVE;
    logic [7:0]  PADDLE_L, PADDLE_R;
    logic [10:0] BALL_H, BALL_V;
    logic [3:0]  SCORE_L, SCORE_R;
    logic        IN_PLAY, HIT;

    always #5 CLOCK = ~CLOCK;

    pong_ball #(.STEP_TICKS(2), .PAUSE_TICKS(4), .WIN_SCORE(9)) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .SERVE    (SERVE),
        .PADDLE_L (PADDLE_L),
        .PADDLE_R (PADDLE_R),
        .BALL_H   (BALL_H),
        .BALL_V   (BALL_V),
        .SCORE_L  (SCORE_L),
        .SCORE_R  (SCORE_R),
        .IN_PLAY  (IN_PLAY),
        .HIT      (HIT)
    );

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        ip;
        logic        hit;
        int          dt;   // cycles since previous change, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLOCK) cyc++;

    task automatic push(input int h, input int v, input int sl, input int sr,
                        input int ip, input int hit, input int dt);
        exp_t e;
        e.h = 11'(h); e.v = 11'(v); e.sl = 4'(sl); e.sr = 4'(sr);
        e.ip = ip[0]; e.hit = hit[0]; e.dt = dt;
        exp_q.push_back(e);
    endtask

    // n consecutive in-play steps on a straight segment starting at (h0,v0)
    task automatic line(input int h0, input int v0, input int dh, input int dv,
                        input int n, input int sl, input int sr);
        for (int k = 0; k < n; k++) push(h0 + k*dh, v0 + k*dv, sl, sr, 1, 0, 2);
    endtask

    task automatic wait_q(input int n, input int limit, input string tag);
        int c;
        c = 0;
        while (exp_q.size() > n && c < limit) begin
            @(negedge CLOCK);
            c++;
        end
        if (exp_q.size() > n) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s pending=%0d required<=%0d", tag, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic serve();
        @(posedge CLOCK); #2 SERVE = 1'b1;
        @(posedge CLOCK); #2 SERVE = 1'b0;
    endtask

    task automatic left_game(input int dy, input int sr, input bit last);
        push(390, 237, 0, sr, 1, 0, 0);
        if (dy == 0) begin
            line(389, 236, -1, -1, 237, 0, sr);
            line(152, 1, -1, 1, 152, 0, sr);
            push(0, 153, 0, sr + 1, 0, 0, 2);
        end else begin
            line(389, 238, -1, 1, 237, 0, sr);
            line(152, 473, -1, -1, 152, 0, sr);
            push(0, 321, 0, sr + 1, 0, 0, 2);
        end
        if (!last) push(390, 237, 0, sr + 1, 0, 0, 4);
        serve();
        wait_q(last ? 0 : 1, 2000, "left_game");
    endtask

    task automatic right_game(input int dy, input int sl);
        push(390, 237, sl, 0, 1, 0, 0);
        if (dy == 0) begin
            line(391, 236, 1, -1, 237, sl, 0);
            line(628, 1, 1, 1, 171, sl, 0);
            push(799, 172, sl + 1, 0, 0, 0, 2);
        end else begin
            line(391, 238, 1, 1, 237, sl, 0);
            line(628, 473, 1, -1, 171, sl, 0);
            push(799, 302, sl + 1, 0, 0, 0, 2);
        end
        push(390, 237, sl + 1, 0, 0, 0, 4);
        serve();
        wait_q(0, 2000, "right_game");
    endtask

    // Monitor: one scoreboard comparison per change of the output vector.
    initial begin
        logic [31:0] prev, cur;
        int          last;
        exp_t        e;
        logic        ok;
        prev = 'x;
        last = 0;
        forever begin
            @(negedge CLOCK or negedge RESET_N);
            #1;
            cur = {BALL_H, BALL_V, SCORE_L, SCORE_R, IN_PLAY, HIT};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got h=%0d v=%0d sl=%0d sr=%0d ip=%0d hit=%0d",
                             BALL_H, BALL_V, SCORE_L, SCORE_R, IN_PLAY, HIT);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (BALL_H === e.h) && (BALL_V === e.v) && (SCORE_L === e.sl) &&
                         (SCORE_R === e.sr) && (IN_PLAY === e.ip) && (HIT === e.hit) &&
                         ((e.dt == 0) || (cyc - last == e.dt));
                    if (!ok) begin
                        errors++;
                        $display("FAIL output_change got h=%0d v=%0d sl=%0d sr=%0d ip=%0d hit=%0d gap=%0d required h=%0d v=%0d sl=%0d sr=%0d ip=%0d hit=%0d gap=%0d",
                                 BALL_H, BALL_V, SCORE_L, SCORE_R, IN_PLAY, HIT, cyc - last,
                                 e.h, e.v, e.sl, e.sr, e.ip, e.hit, e.dt);
                    end
                end
                last = cyc;
                prev = cur;
            end
        end
    end

    initial begin
        int c;
        RESET_N  = 1'b0;
        SERVE    = 1'b0;
        PADDLE_L = 8'd0;
        PADDLE_R = 8'd20;
        push(390, 237, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLOCK);
        #2 RESET_N = 1'b1;
        repeat (3) @(posedge CLOCK);

        // Game 1: bottom wall, right paddle hit (rows 320..399), top wall, left miss.
        push(390, 237, 0, 0, 1, 0, 0);
        line(391, 238, 1, 1, 237, 0, 0);
        line(628, 473, 1, -1, 143, 0, 0);
        push(769, 330, 0, 0, 1, 1, 2);
        push(769, 330, 0, 0, 1, 0, 1);
        push(768, 329, 0, 0, 1, 0, 1);
        line(767, 328, -1, -1, 329, 0, 0);
        line(438, 1, -1, 1, 438, 0, 0);
        push(0, 439, 0, 1, 0, 0, 2);
        push(390, 237, 0, 1, 0, 0, 4);
        serve();
        wait_q(0, 3000, "game1");

        // Left misses until the computer reaches the winning score.
        for (int g = 0; g < 8; g++) begin
            left_game(g % 2, g + 1, g == 7);
            if (g == 6) begin
                @(posedge CLOCK); #2 SERVE = 1'b1;
                repeat (2) @(posedge CLOCK);
                #2 SERVE = 1'b0;
            end
            wait_q(0, 50, "idle");
        end

        // Pause elapses into OVER (ball stays put); serve restarts with cleared scores.
        repeat (8) @(posedge CLOCK);
        push(390, 237, 0, 0, 0, 0, 0);
        serve();
        wait_q(0, 20, "restart");

        PADDLE_R = 8'd0;
        for (int g = 0; g < 3; g++) right_game(g % 2, g);

        // Mid-flight asynchronous reset at H=500 with SCORE_L=3.
        push(390, 237, 3, 0, 1, 0, 0);
        line(391, 238, 1, 1, 110, 3, 0);
        push(390, 237, 0, 0, 0, 0, 0);
        serve();
        c = 0;
        while (BALL_H != 11'd500 && c < 1000) begin
            @(negedge CLOCK);
            c++;
        end
        if (BALL_H != 11'd500) begin
            checks++;
            errors++;
            $display("FAIL reach_h500 got h=%0d required h=500", BALL_H);
        end
        @(posedge CLOCK);
        #2 RESET_N = 1'b0;
        repeat (2) @(posedge CLOCK);
        #2 RESET_N = 1'b1;
        repeat (5) @(posedge CLOCK);
        wait_q(0, 10, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
